// File: rtl/sha_state_accum.sv
// SHA chaining-state register: lane-serial feed-forward add of the working variables,
// midstate cache for nonce iteration, and IV reload after the FINAL (first-hash) result.
module sha_state_lane #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);
    assign sum = a + b;
endmodule

module sha_state_accum #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int LANES     = 2,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  op,
    input  logic                        save_mid,
    input  logic [NUM_WORDS*WORD_W-1:0] work,
    output logic [NUM_WORDS*WORD_W-1:0] digest,
    output logic                        out_valid,
    output logic                        out_final,
    output logic [NUM_WORDS*WORD_W-1:0] state_q,
    output logic                        mid_valid,
    output logic                        mid_err
);
    localparam int BEATS = NUM_WORDS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WIDX  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [1:0] OP_INIT    = 2'b00;
    localparam logic [1:0] OP_ACC     = 2'b01;
    localparam logic [1:0] OP_FINAL   = 2'b10;
    localparam logic [1:0] OP_RESTORE = 2'b11;

    // Word 0 sits in the MSBs, so word i lives at packed index NUM_WORDS-1-i.
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] words_t;
    typedef enum logic [1:0] {S_IDLE, S_SUM, S_DONE} fsm_t;
    typedef struct packed {
        logic is_final;
        logic save;
    } cmd_t;

    fsm_t            fsm_q, fsm_d;
    logic [BW-1:0]   beat_q, beat_d;
    words_t          chain_q, chain_d;
    words_t          digest_q, digest_d;
    words_t          mid_q, mid_d;
    words_t          work_q, work_d;
    cmd_t            cmd_q, cmd_d;
    logic            mid_valid_q, mid_valid_d;
    logic            out_valid_q, out_valid_d;
    logic            out_final_q, out_final_d;
    logic            mid_err_q, mid_err_d;

    logic [LANES-1:0][WIDX-1:0]   lane_idx;
    logic [LANES-1:0][WORD_W-1:0] lane_sum;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = WIDX'(NUM_WORDS - 1 - int'(beat_q) * LANES - l);
        sha_state_lane #(.WORD_W(WORD_W)) u_lane (
            .a   (chain_q[lane_idx[l]]),
            .b   (work_q[lane_idx[l]]),
            .sum (lane_sum[l])
        );
    end

    always_comb begin
        fsm_d       = fsm_q;
        beat_d      = beat_q;
        chain_d     = chain_q;
        digest_d    = digest_q;
        mid_d       = mid_q;
        work_d      = work_q;
        cmd_d       = cmd_q;
        mid_valid_d = mid_valid_q;
        out_valid_d = 1'b0;
        out_final_d = 1'b0;
        mid_err_d   = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_INIT: chain_d = IV;
                        OP_RESTORE: begin
                            if (mid_valid_q) begin
                                chain_d = mid_q;
                            end else begin
                                chain_d   = IV;
                                mid_err_d = 1'b1;
                            end
                        end
                        default: begin
                            work_d         = work;
                            cmd_d.is_final = (op == OP_FINAL);
                            cmd_d.save     = save_mid;
                            beat_d         = '0;
                            fsm_d          = S_SUM;
                        end
                    endcase
                end
            end
            S_SUM: begin
                for (int l = 0; l < LANES; l++) begin
                    digest_d[lane_idx[l]] = lane_sum[l];
                end
                if (beat_q == BW'(BEATS - 1)) begin
                    fsm_d       = S_DONE;
                    out_valid_d = 1'b1;
                    out_final_d = cmd_q.is_final;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
                // FINAL closes the first hash; the second hash starts from IV.
                if (cmd_q.is_final) begin
                    chain_d = IV;
                end else begin
                    chain_d = digest_q;
                    if (cmd_q.save) begin
                        mid_d       = digest_q;
                        mid_valid_d = 1'b1;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            beat_q      <= '0;
            chain_q     <= IV;
            digest_q    <= '0;
            mid_q       <= '0;
            work_q      <= '0;
            cmd_q       <= '0;
            mid_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_final_q <= 1'b0;
            mid_err_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            beat_q      <= beat_d;
            chain_q     <= chain_d;
            digest_q    <= digest_d;
            mid_q       <= mid_d;
            work_q      <= work_d;
            cmd_q       <= cmd_d;
            mid_valid_q <= mid_valid_d;
            out_valid_q <= out_valid_d;
            out_final_q <= out_final_d;
            mid_err_q   <= mid_err_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign digest    = digest_q;
    assign out_valid = out_valid_q;
    assign out_final = out_final_q;
    assign state_q   = chain_q;
    assign mid_valid = mid_valid_q;
    assign mid_err   = mid_err_q;
endmodule

// File: doc/sha_state_accum.md
Name: sha_state_accum

Overview:
Parametrised hash-state chaining register for the mining datapath. It holds all NUM_WORDS chaining words, which are H0..H7 for SHA-256. After each compression it adds the working variables into the state and publishes the digest. It caches a midstate so nonce iterations skip the fixed first header block, and it reloads the IV automatically between the first and second hash. It sits between the round core and the nonce/compare logic, and replaces the per-word hard-wired state registers.

Parameters:
WORD_W, 32, width of one chaining word; all adds are modulo 2^WORD_W.
NUM_WORDS, 8, number of chaining words.
LANES, 2, words added per cycle; NUM_WORDS % LANES must be 0. BEATS = NUM_WORDS/LANES.
IV, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, initial state of NUM_WORDS*WORD_W bits, word 0 in the MSBs.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  command valid
in_ready  out  1  command accepted when in_valid&in_ready at the clock edge
op  in  2  00 INIT, 01 ACC, 10 FINAL, 11 RESTORE
save_mid  in  1  with ACC: copy the result into midstate
work  in  NUM_WORDS*WORD_W  working variables a..h from the round core, word 0 in the MSBs
digest  out  NUM_WORDS*WORD_W  last ACC/FINAL result, registered
out_valid  out  1  one-cycle pulse when digest is updated
out_final  out  1  qualifies out_valid: 1 means the result came from FINAL
state_q  out  NUM_WORDS*WORD_W  current chaining state
mid_valid  out  1  midstate register holds a saved value
mid_err  out  1  one-cycle pulse: RESTORE issued while mid_valid=0

Behaviour:
- Reset (async assert, sync release): state=IV, digest=0, midstate=0, mid_valid=0, out_valid=0, out_final=0, mid_err=0, FSM=IDLE. Reset mid-operation aborts the command with no out_valid.
- FSM states:
  - IDLE: in_ready=1.
  - SUM: in_ready=0, runs for BEATS cycles.
  - DONE: in_ready=0, lasts 1 cycle.
- INIT accepted: state<=IV at the accept edge. FSM stays IDLE, no out_valid.
- RESTORE accepted:
  - If mid_valid=1: state<=midstate.
  - If mid_valid=0: state<=IV and mid_err pulses the next cycle.
  - FSM stays IDLE, no out_valid.
- ACC/FINAL accepted at edge T:
  - work is latched into an internal register and op/save_mid are captured; FSM goes to SUM, beat=0.
  - Edge T+k (k=1..BEATS): digest words [(k-1)*LANES .. k*LANES-1] <= state word + work word, each modulo 2^WORD_W. There is no carry between words.
  - On the final beat, FSM goes to DONE.
  - Accept-to-out_valid latency is BEATS edges; with defaults, out_valid is high in the cycle after edge T+4.
- DONE cycle (a single edge):
  - out_valid=1; out_final=1 for FINAL, 0 for ACC.
  - At the DONE edge, ACC: state<=digest. If save_mid was set, also midstate<=digest and mid_valid<=1.
  - At the DONE edge, FINAL: state<=IV, so the state is ready for the second hash. save_mid is ignored.
  - FSM goes to IDLE; in_ready=1 in the next cycle.
- digest holds its value until the next ACC/FINAL overwrites it beat by beat. It is only guaranteed coherent while out_valid=1 and afterwards until the next accept.
- During SUM the state register is unchanged. state_q reflects the committed state only.
- in_valid while in_ready=0 is not accepted. The source must hold op, work and save_mid until it is accepted.
- midstate persists across INIT and FINAL. It is cleared only by reset. A new ACC with save_mid overwrites it.
- Lane rule: beat b handles word indices b*LANES..b*LANES+LANES-1. LANES=NUM_WORDS gives a single-beat sum, BEATS=1.

Test Plan:
- Reset then idle: state_q=IV (word7=0x5be0cd19, word6=0x1f83d9ab), in_ready=1, digest=0, mid_valid=0, no out_valid.
- INIT, then ACC with work word0=0x506e3058 and other words 0 → out_valid exactly 4 cycles after the accept edge, out_final=0, digest word0=0xba7816bf, other words=IV, state_q=digest.
- Wrap: after INIT+ACC setting state word3=0xffffffff, ACC with work word3=0x00000001 and word2=0x00000001 → word3=0x00000000, word2 unaffected by the carry (=prior word2+1).
- Nonce loop:
  - ACC save_mid=1 gives midstate M, mid_valid=1.
  - FINAL → out_final=1 and state_q=IV afterwards.
  - RESTORE → state_q=M; a second RESTORE also gives M.
- RESTORE with mid_valid=0 after reset → mid_err pulses 1 cycle, state_q=IV. in_valid held during SUM is not accepted until in_ready=1, and no command is lost.
- Assert rst_n=0 in beat 2 of an ACC → all outputs return to reset values immediately, no out_valid. With LANES=8, latency = 1 beat.
